// File: rtl/fifo_write_arbiter.sv
// Write-side arbiter sharing one FIFO write port among NREQ requesters in bounded bursts.
// Optional build macro FIFO_ARB_STRICT_PRIO_EN selects strict lowest-index priority in place of round-robin.
module fifo_write_arbiter #(
  parameter int SIZE  = 8,
  parameter int NREQ  = 4,
  parameter int BURST = 4
) (
  input  logic                      w_clk,
  input  logic                      n_rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*SIZE-1:0]      req_data,
  output logic [NREQ-1:0]           gnt,
  input  logic                      f_flag,
  input  logic                      almost_full_flag,
  output logic                      valid_write,
  output logic [SIZE-1:0]           data_in,
  output logic                      busy,
  output logic [$clog2(NREQ)-1:0]   owner
);

  localparam int OW = $clog2(NREQ);
  localparam int CW = $clog2(BURST + 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            valid_write_q, valid_write_d;
  logic [SIZE-1:0] data_in_q, data_in_d;
  logic            busy_q, busy_d;

  logic            stall;
  logic            owner_req;
  logic            accept;
  logic [SIZE-1:0] lane_sel;
  logic [OW-1:0]   pick;

`ifdef FIFO_ARB_STRICT_PRIO_EN
  function automatic logic [OW-1:0] pick_next(input logic [NREQ-1:0] r,
                                              input logic [OW-1:0]   from);
    logic [OW-1:0] sel;
    logic          unused_from;
    sel         = '0;
    unused_from = ^from;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (r[i]) sel = OW'(i);
    end
    return sel;
  endfunction
`else
  // Search starts just above the previous owner and wraps, giving round-robin fairness.
  function automatic logic [OW-1:0] pick_next(input logic [NREQ-1:0] r,
                                              input logic [OW-1:0]   from);
    logic [OW-1:0] sel;
    logic          found;
    int            idx;
    sel   = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(from) + k) % NREQ;
      if (!found && r[idx]) begin
        sel   = OW'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction
`endif

  always_comb begin
    lane_sel  = '0;
    owner_req = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == OW'(i)) begin
        lane_sel  = req_data[i*SIZE +: SIZE];
        owner_req = req[i];
      end
    end
  end

  assign stall  = f_flag | almost_full_flag;
  assign accept = (state_q == ST_BURST) && owner_req && !stall;
  assign pick   = pick_next(req, last_q);

  always_comb begin
    gnt = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (accept && (owner_q == OW'(i))) gnt[i] = 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    valid_write_d = accept;
    data_in_d     = accept ? lane_sel : data_in_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          owner_d = pick;
          cnt_d   = '0;
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(BURST - 1)) begin
            state_d = ST_IDLE;
            last_d  = owner_q;
          end
        end else if (!stall && !owner_req) begin
          // Owner ran dry: release the port early rather than idle in BURST.
          state_d = ST_IDLE;
          last_d  = owner_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_BURST);
  end

  always_ff @(posedge w_clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= ST_IDLE;
      owner_q       <= '0;
      last_q        <= OW'(NREQ - 1);
      cnt_q         <= '0;
      valid_write_q <= 1'b0;
      data_in_q     <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_q        <= last_d;
      cnt_q         <= cnt_d;
      valid_write_q <= valid_write_d;
      data_in_q     <= data_in_d;
      busy_q        <= busy_d;
    end
  end

  assign valid_write = valid_write_q;
  assign data_in     = data_in_q;
  assign busy        = busy_q;
  assign owner       = owner_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_fifo_write_arbiter;
  localparam int SIZE  = 8;
  localparam int NREQ  = 4;
  localparam int BURST = 4;

  logic                 w_clk = 1'b0;
  logic                 n_rst;
  logic [NREQ-1:0]      req;
  logic [NREQ*SIZE-1:0] req_data;
  logic [NREQ-1:0]      gnt;
  logic                 f_flag;
  logic                 almost_full_flag;
  logic                 valid_write;
  logic [SIZE-1:0]      data_in;
  logic                 busy;
  logic [1:0]           owner;

  logic [SIZE-1:0] lane [NREQ];

  always #5 w_clk = ~w_clk;

  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign req_data[g*SIZE +: SIZE] = lane[g];
  end

  fifo_write_arbiter #(.SIZE(SIZE), .NREQ(NREQ), .BURST(BURST)) dut (
    .w_clk            (w_clk),
    .n_rst            (n_rst),
    .req              (req),
    .req_data         (req_data),
    .gnt              (gnt),
    .f_flag           (f_flag),
    .almost_full_flag (almost_full_flag),
    .valid_write      (valid_write),
    .data_in          (data_in),
    .busy             (busy),
    .owner            (owner)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: who owns the port, how many words it has delivered, who went last.
  bit              m_busy;
  int              m_owner;
  int              m_last;
  int              m_words;
  bit              e_vw;
  logic [SIZE-1:0] e_data;

  logic [NREQ-1:0] last_gnt;
  bit              prev_busy;
  int              stepn;
  int              dut_picks[$];
  int              writes[$];
  int              wr_step[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_choose(input logic [NREQ-1:0] r);
    int i;
`ifdef FIFO_ARB_STRICT_PRIO_EN
    for (int k = 0; k < NREQ; k++) if (r[k]) return k;
`else
    for (int k = 1; k <= NREQ; k++) begin
      i = (m_last + k) % NREQ;
      if (r[i]) return i;
    end
`endif
    return 0;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_last = NREQ - 1; m_words = 0;
    e_vw = 0; e_data = '0; prev_busy = 0; stepn = 0;
    dut_picks.delete(); writes.delete(); wr_step.delete();
  endtask

  task automatic step();
    logic [NREQ-1:0] eg;
    bit stall;
    @(negedge w_clk);
    stall = f_flag | almost_full_flag;
    eg = '0;
    if (m_busy && req[m_owner] && !stall) eg[m_owner] = 1'b1;
    chk("gnt", 32'(gnt), 32'(eg));
    last_gnt = gnt;
    e_vw = (eg != 0);
    if (e_vw) e_data = lane[m_owner];
    if (!m_busy) begin
      if (req != 0) begin
        m_owner = m_choose(req); m_busy = 1; m_words = 0;
      end
    end else if (e_vw) begin
      m_words++;
      if (m_words == BURST) begin m_busy = 0; m_last = m_owner; end
    end else if (!stall && !req[m_owner]) begin
      m_busy = 0; m_last = m_owner;
    end
    @(posedge w_clk); #1;
    stepn++;
    chk("valid_write", 32'(valid_write), 32'(e_vw));
    chk("data_in", 32'(data_in), 32'(e_data));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("owner", 32'(owner), 32'(m_owner));
    if (busy && !prev_busy) dut_picks.push_back(int'(owner));
    prev_busy = busy;
    if (valid_write) begin
      writes.push_back(int'(data_in));
      wr_step.push_back(stepn);
    end
  endtask

  task automatic do_reset(input int n);
    n_rst = 1'b0;
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_vw", 32'(valid_write), 32'h0);
    chk("rst_data", 32'(data_in), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_owner", 32'(owner), 32'h0);
    repeat (n) @(posedge w_clk);
    #1;
    chk("rst_hold_vw", 32'(valid_write), 32'h0);
    chk("rst_hold_gnt", 32'(gnt), 32'h0);
    model_reset();
    n_rst = 1'b1;
  endtask

  task automatic after_grant(input int keep_pct);
    for (int i = 0; i < NREQ; i++) begin
      if (last_gnt[i]) begin
        if (int'($urandom_range(99)) < keep_pct) lane[i] = SIZE'($urandom);
        else req[i] = 1'b0;
      end
    end
  endtask

  initial begin
    int vals[5];
    int acc;
    int exp_rr[4];
    n_rst = 1'b0; req = '0; f_flag = 0; almost_full_flag = 0;
    for (int i = 0; i < NREQ; i++) lane[i] = '0;
    model_reset();

    // Reset with all lanes requesting; first burst must go to requester 0.
    req = 4'b1111;
    for (int i = 0; i < NREQ; i++) lane[i] = SIZE'($urandom);
    #2;
    do_reset(3);
    step();
    chk("rst_first_owner_cnt", 32'(dut_picks.size()), 32'd1);
    if (dut_picks.size() > 0) chk("rst_first_owner", 32'(dut_picks[0]), 32'd0);

    // Single requester on lane 2; 503 does not fit SIZE=8 so its low byte 247 is used.
    req = '0;
    do_reset(1);
    vals = '{21, 247, 90, 10, 20};
    acc = 0;
    lane[2] = SIZE'(vals[0]);
    req = 4'b0100;
    repeat (9) begin
      step();
      if (last_gnt[2]) begin
        acc++;
        if (acc < 5) lane[2] = SIZE'(vals[acc]);
        else req[2] = 1'b0;
      end
    end
    chk("single_nwrites", 32'(writes.size()), 32'd5);
    for (int i = 0; i < 5 && i < writes.size(); i++) begin
      chk("single_data", 32'(writes[i]), 32'(vals[i]));
    end
    // Pick at step 1, four accepts at steps 2-5, idle at 6, fifth word at 7.
    if (wr_step.size() == 5) begin
      chk("single_t0", 32'(wr_step[0]), 32'd2);
      chk("single_t3", 32'(wr_step[3]), 32'd5);
      chk("single_t4", 32'(wr_step[4]), 32'd7);
    end

    // Round-robin with lanes 0, 1, 3 always requesting.
    req = '0;
    do_reset(1);
    req = 4'b1011;
    repeat (20) begin
      step();
      after_grant(100);
    end
`ifdef FIFO_ARB_STRICT_PRIO_EN
    exp_rr = '{0, 0, 0, 0};
`else
    exp_rr = '{0, 1, 3, 0};
`endif
    chk("rr_nbursts", 32'(dut_picks.size() >= 4), 32'd1);
    for (int i = 0; i < 4 && i < dut_picks.size(); i++) begin
      chk("rr_owner", 32'(dut_picks[i]), 32'(exp_rr[i]));
    end
    chk("rr_nwrites", 32'(writes.size()), 32'd16);

    // Backpressure: almost-full for 5 cycles after 2 accepts.
    req = '0;
    do_reset(1);
    lane[0] = SIZE'($urandom);
    req = 4'b0001;
    acc = 0;
    for (int i = 0; i < 10 && acc < 2; i++) begin
      step();
      if (last_gnt[0]) acc++;
      after_grant(100);
    end
    chk("bp_pre_accepts", 32'(acc), 32'd2);
    almost_full_flag = 1'b1;
    acc = 0;
    repeat (5) begin
      step();
      if (last_gnt != 0) acc++;
    end
    chk("bp_stall_grants", 32'(acc), 32'd0);
    chk("bp_stall_busy", 32'(busy), 32'd1);
    almost_full_flag = 1'b0;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (last_gnt[0]) acc++;
      after_grant(100);
      if (!busy) break;
    end
    chk("bp_post_accepts", 32'(acc), 32'd2);

    // Early release: owner 1 drops after one word, then lane 2 is served.
    req = '0;
    do_reset(1);
    lane[1] = SIZE'($urandom);
    lane[2] = SIZE'($urandom);
    req = 4'b0110;
    repeat (6) begin
      step();
      if (last_gnt[1]) req[1] = 1'b0;
      if (last_gnt[2]) lane[2] = SIZE'($urandom);
    end
    chk("early_nbursts", 32'(dut_picks.size()), 32'd2);
    if (dut_picks.size() >= 2) begin
      chk("early_owner0", 32'(dut_picks[0]), 32'd1);
      chk("early_owner1", 32'(dut_picks[1]), 32'd2);
    end

    // Randomized traffic with random full/almost-full flags.
    req = '0;
    do_reset(1);
    repeat (400) begin
      step();
      after_grant(60);
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && $urandom_range(99) < 30) begin
          lane[i] = SIZE'($urandom);
          req[i]  = 1'b1;
        end
      end
      f_flag           = ($urandom_range(99) < 8);
      almost_full_flag = ($urandom_range(99) < 15);
    end
    f_flag = 0; almost_full_flag = 0;

    // Reset while a grant is pending: the word must never be written.
    req = '0;
    do_reset(1);
    lane[2] = SIZE'($urandom);
    req = 4'b0100;
    step();
    @(negedge w_clk);
    chk("mb_gnt", 32'(gnt), 32'h4);
    do_reset(1);
    req = 4'b0011;
    step();
    chk("mb_restart_cnt", 32'(dut_picks.size()), 32'd1);
    if (dut_picks.size() > 0) chk("mb_restart_owner", 32'(dut_picks[0]), 32'd0);
    repeat (3) begin
      step();
      after_grant(100);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
